gcm_aes_job_sequencer: RTL and testbench
========================================

// Module: gcm_aes_job_sequencer
// PURPOSE
// Generic job sequencer between a host stream interface and the GCM-AES core.
// Takes one job descriptor (key, IV, AAD byte length, payload byte length) and a 128-bit block stream.
// Issues key/start, IV, AAD blocks, then payload blocks to the core, pacing each block on dii_data_not_ready.
// Forwards core output blocks and the final tag back to the host.
// PARAMETERS
// LEN_W    16  width of AAD/payload byte-length fields and remaining-byte counters
// HOLDOFF  1   cycles after each dii_data_vld pulse during which dii_data_not_ready is ignored (1..3)
// PORTS
// clk            in   1        clock
// clrn           in   1        async active-low reset
// job_start      in   1        start pulse; job_* sampled in the same cycle
// job_key        in   128      secret key
// job_iv         in   128      IV/nonce for the core
// job_aad_len    in   LEN_W    AAD length in bytes
// job_pld_len    in   LEN_W    payload length in bytes
// job_busy       out  1        job in progress
// job_done       out  1        1-cycle pulse, concurrent with tag_valid
// job_err        out  1        1-cycle pulse: job_start with both lengths 0
// in_data        in   128      AAD/payload block, valid bytes LSB-aligned
// in_valid       in   1        in_data valid
// in_ready       out  1        sequencer accepts in_data this cycle
// out_data       out  128      payload result block
// out_size       out  4        valid bytes minus 1
// out_valid      out  1        out_data valid; no backpressure
// out_last       out  1        final payload result block
// tag            out  128      authentication tag, held until next job_start
// tag_valid      out  1        1-cycle pulse
// cii_K, cii_ctl_vld, cii_IV_vld, dii_data[127:0], dii_data_size[3:0], dii_data_vld, dii_data_type, dii_last_word: out to core
// dii_data_not_ready, Out_data[127:0], Out_vld, Tag_vld, Out_data_size[3:0], Out_last_word: in from core
// BEHAVIOUR
// Reset: all outputs 0; state IDLE; both counters 0. All core-facing outputs are registered.
// Reset mid-job: immediate abort to IDLE; no job_done or tag_valid.
// IDLE:
//  - job_start with aad_len=pld_len=0: job_err pulse; remain IDLE.
//  - Otherwise latch lengths into rem_aad/rem_pld and drive cii_K=job_key and cii_ctl_vld=1 for 1 cycle -> KEY.
//  - job_start while job_busy=1 is ignored.
// KEY: dii_data=job_iv, cii_IV_vld=1 -> IV.
// IV: hold cii_IV_vld=1 until dii_data_not_ready=0 is sampled, then -> FETCH.
// FETCH:
//  - Phase is AAD while rem_aad!=0, else PLD. in_ready=1 only in FETCH with rem!=0.
//  - On in_valid&in_ready, the next cycle drives:
//    - dii_data_vld=1 for exactly 1 cycle.
//    - dii_data_type=1 in AAD phase, 0 in PLD phase.
//    - dii_data_size = (rem>=16) ? 15 : rem-1.
//    - dii_data = in_data with bytes above size forced to 0.
//  - rem is reduced by 16, saturating at 0.
//  - dii_last_word=1 on the final block of the job: last PLD block, or last AAD block if pld_len=0. It is held until IDLE.
//  - Goes to HOLD after each block.
// HOLD: ignore dii_data_not_ready for HOLDOFF cycles, then wait for dii_data_not_ready=0; -> FETCH, or -> WAIT_TAG if job bytes exhausted.
// Output path, any busy state, 1-cycle registered latency:
//  - Out_vld&!Tag_vld -> out_valid=1; out_data/out_size/out_last = Out_data/Out_data_size/Out_last_word.
//  - Out_vld&Tag_vld -> tag=Out_data; tag_valid=1 and job_done=1 for 1 cycle; -> IDLE. Accepted in any busy state.
// job_busy=1 in every state except IDLE. in_valid outside FETCH is not consumed (in_ready=0).
// TESTING
// 1. Reset mid-payload (clrn low 1 cycle) -> all outputs 0, job_busy=0 next edge, no tag_valid; new job then completes normally.
// 2. NIST GCM TC4: K=feffe9928665731c6d6a8f9467308308, aad_len=20, pld_len=60.
//    -> AAD sizes 15,3 (type 1); PLD sizes 15,15,15,11; dii_last_word on 4th PLD block.
//    -> 4 out_valid blocks, out_last on the 4th; tag=5bc94fbc3221a5db94fae95ae7121a47.
// 3. aad_len=0, pld_len=16 -> no type=1 block; one PLD block size 15 with dii_last_word=1.
// 4. aad_len=5, pld_len=0 -> one AAD block size 4, dii_last_word=1, upper 11 bytes of dii_data are 0.
//    -> tag_valid and job_done fire with no out_valid.
// 5. aad_len=pld_len=0 -> job_err pulse, job_busy stays 0.
//    job_start during a busy job -> ignored, descriptor unchanged.
// 6. Core holds dii_data_not_ready=1 for 20 cycles after a block -> in_ready=0 and no dii_data_vld until it drops.
//    Stalling in_valid low for 10 cycles -> dii_data_vld delayed accordingly.

Source files
------------

// File: rtl/gcm_aes_job_sequencer.sv
// gcm_aes_job_sequencer
// Runs one GCM-AES job at a time between a host block stream and the core.
// A job is: load key, load IV, push the AAD blocks, push the payload blocks,
// then wait for the tag. Core output blocks and the tag come back to the host.
//
// Ports
//   clk, clrn              clock, asynchronous active-low reset
//   job_*                  descriptor, sampled with job_start in IDLE
//   job_busy/done/err      job status (done/err are 1-cycle pulses)
//   in_data/valid/ready    host block stream (AAD first, then payload)
//   out_*                  payload result blocks from the core (no backpressure)
//   tag, tag_valid         authentication tag, held until the next job
//   cii_*, dii_*           registered command/data outputs to the core
//   dii_data_not_ready     core pacing input
//   Out_*, Tag_vld         core result inputs
//   fsm_state              current FSM state (debug observation)
//
// Handshake: a host block transfers on a rising clk edge where both in_valid
// and in_ready are 1; in_valid may stay high while in_ready is 0 and nothing
// is consumed. out_valid and tag_valid are single-cycle with no ready.
module gcm_aes_job_sequencer #(
  parameter int LEN_W   = 16,
  parameter int HOLDOFF = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             job_start,
  input  logic [127:0]     job_key,
  input  logic [127:0]     job_iv,
  input  logic [LEN_W-1:0] job_aad_len,
  input  logic [LEN_W-1:0] job_pld_len,
  output logic             job_busy,
  output logic             job_done,
  output logic             job_err,
  input  logic [127:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [127:0]     out_data,
  output logic [3:0]       out_size,
  output logic             out_valid,
  output logic             out_last,
  output logic [127:0]     tag,
  output logic             tag_valid,
  output logic [127:0]     cii_K,
  output logic             cii_ctl_vld,
  output logic             cii_IV_vld,
  output logic [127:0]     dii_data,
  output logic [3:0]       dii_data_size,
  output logic             dii_data_vld,
  output logic             dii_data_type,
  output logic             dii_last_word,
  input  logic             dii_data_not_ready,
  input  logic [127:0]     Out_data,
  input  logic             Out_vld,
  input  logic             Tag_vld,
  input  logic [3:0]       Out_data_size,
  input  logic             Out_last_word,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_IV, S_FETCH, S_HOLD, S_WAIT_TAG
  } state_t;

  localparam logic [LEN_W-1:0] BLK       = LEN_W'(16);
  localparam logic [1:0]       HOLD_INIT = 2'(HOLDOFF);

  state_t           state;
  logic [LEN_W-1:0] rem_aad;
  logic [LEN_W-1:0] rem_pld;
  logic [1:0]       hold_cnt;

  logic             aad_phase;
  logic [LEN_W-1:0] cur_rem;
  logic [LEN_W-1:0] rem_next;
  logic [3:0]       blk_size;
  logic [127:0]     blk_mask;
  logic             final_blk;
  logic             take;

  // Current block geometry, derived from whichever counter is active.
  assign aad_phase = (rem_aad != '0);
  assign cur_rem   = aad_phase ? rem_aad : rem_pld;
  assign rem_next  = (cur_rem >= BLK) ? (cur_rem - BLK) : '0;
  assign blk_size  = (cur_rem >= BLK) ? 4'd15 : 4'(cur_rem - 1'b1);
  // Keep bytes 0..blk_size, zero everything above.
  assign blk_mask  = ~128'd0 >> {4'd15 - blk_size, 3'b000};
  // Last block of the whole job: AAD only counts when there is no payload.
  assign final_blk = aad_phase ? ((rem_aad <= BLK) && (rem_pld == '0))
                               : (rem_pld <= BLK);

  assign job_busy  = (state != S_IDLE);
  assign in_ready  = (state == S_FETCH) && ((rem_aad != '0) || (rem_pld != '0));
  assign take      = in_valid && in_ready;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state         <= S_IDLE;
      rem_aad       <= '0;
      rem_pld       <= '0;
      hold_cnt      <= '0;
      job_done      <= 1'b0;
      job_err       <= 1'b0;
      out_data      <= '0;
      out_size      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      tag           <= '0;
      tag_valid     <= 1'b0;
      cii_K         <= '0;
      cii_ctl_vld   <= 1'b0;
      cii_IV_vld    <= 1'b0;
      dii_data      <= '0;
      dii_data_size <= '0;
      dii_data_vld  <= 1'b0;
      dii_data_type <= 1'b0;
      dii_last_word <= 1'b0;
    end else begin
      cii_ctl_vld  <= 1'b0;
      dii_data_vld <= 1'b0;
      job_done     <= 1'b0;
      job_err      <= 1'b0;
      out_valid    <= 1'b0;
      tag_valid    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (job_start) begin
            if ((job_aad_len == '0) && (job_pld_len == '0)) begin
              job_err <= 1'b1;
            end else begin
              rem_aad       <= job_aad_len;
              rem_pld       <= job_pld_len;
              cii_K         <= job_key;
              cii_ctl_vld   <= 1'b1;
              // IV is parked on dii_data now; it is qualified by cii_IV_vld next.
              dii_data      <= job_iv;
              dii_last_word <= 1'b0;
              state         <= S_KEY;
            end
          end
        end
        S_KEY: begin
          cii_IV_vld <= 1'b1;
          state      <= S_IV;
        end
        S_IV: begin
          if (!dii_data_not_ready) begin
            cii_IV_vld <= 1'b0;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (take) begin
            dii_data_vld  <= 1'b1;
            dii_data_type <= aad_phase;
            dii_data_size <= blk_size;
            dii_data      <= in_data & blk_mask;
            if (final_blk) dii_last_word <= 1'b1;
            if (aad_phase) rem_aad <= rem_next;
            else           rem_pld <= rem_next;
            hold_cnt      <= HOLD_INIT;
            state         <= S_HOLD;
          end
        end
        S_HOLD: begin
          // The core may raise not_ready a little after dii_data_vld, so the
          // first HOLDOFF cycles do not trust it.
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (!dii_data_not_ready) begin
            state <= ((rem_aad == '0) && (rem_pld == '0)) ? S_WAIT_TAG : S_FETCH;
          end
        end
        S_WAIT_TAG: ;
        default: state <= S_IDLE;
      endcase

      // Core results are forwarded from any busy state; the tag ends the job
      // and overrides whatever state the sequencer was in.
      if ((state != S_IDLE) && Out_vld) begin
        if (Tag_vld) begin
          tag           <= Out_data;
          tag_valid     <= 1'b1;
          job_done      <= 1'b1;
          cii_IV_vld    <= 1'b0;
          dii_last_word <= 1'b0;
          state         <= S_IDLE;
        end else begin
          out_valid <= 1'b1;
          out_data  <= Out_data;
          out_size  <= Out_data_size;
          out_last  <= Out_last_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_gcm_aes_job_sequencer.sv
// tb_gcm_aes_job_sequencer
// Drives jobs into gcm_aes_job_sequencer with a small core model on the far
// side. Expected core-facing blocks are derived from the job lengths alone
// (16-byte chunks, AAD then payload, bytes above the chunk size zeroed).
module tb_gcm_aes_job_sequencer;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             clrn;
  logic             job_start;
  logic [127:0]     job_key, job_iv;
  logic [LEN_W-1:0] job_aad_len, job_pld_len;
  logic             job_busy, job_done, job_err;
  logic [127:0]     in_data;
  logic             in_valid, in_ready;
  logic [127:0]     out_data;
  logic [3:0]       out_size;
  logic             out_valid, out_last;
  logic [127:0]     tag;
  logic             tag_valid;
  logic [127:0]     cii_K;
  logic             cii_ctl_vld, cii_IV_vld;
  logic [127:0]     dii_data;
  logic [3:0]       dii_data_size;
  logic             dii_data_vld, dii_data_type, dii_last_word;
  logic             dii_data_not_ready;
  logic [127:0]     Out_data;
  logic             Out_vld, Tag_vld;
  logic [3:0]       Out_data_size;
  logic             Out_last_word;
  logic [2:0]       fsm_state;

  gcm_aes_job_sequencer #(.LEN_W(LEN_W), .HOLDOFF(1)) dut (
    .clk(clk), .clrn(clrn),
    .job_start(job_start), .job_key(job_key), .job_iv(job_iv),
    .job_aad_len(job_aad_len), .job_pld_len(job_pld_len),
    .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_size(out_size), .out_valid(out_valid), .out_last(out_last),
    .tag(tag), .tag_valid(tag_valid),
    .cii_K(cii_K), .cii_ctl_vld(cii_ctl_vld), .cii_IV_vld(cii_IV_vld),
    .dii_data(dii_data), .dii_data_size(dii_data_size), .dii_data_vld(dii_data_vld),
    .dii_data_type(dii_data_type), .dii_last_word(dii_last_word),
    .dii_data_not_ready(dii_data_not_ready),
    .Out_data(Out_data), .Out_vld(Out_vld), .Tag_vld(Tag_vld),
    .Out_data_size(Out_data_size), .Out_last_word(Out_last_word),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [133:0] exp_q[$];        // {type, last, size, data} per core block
  logic [132:0] exp_out_q[$];    // {last, size, data} per out_valid
  logic [132:0] pend_q[$];       // core results not yet emitted
  logic [127:0] blk_data_q[$];   // host blocks still to send

  logic [127:0] exp_key, exp_iv, exp_tag;
  bit           key_exp, iv_seen;
  int           n_out, exp_nout, done_cnt, vld_cnt;
  int           iv_stall, blk_stall;

  task automatic check(input string name, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // ---------------- core model ----------------
  int  nr_cnt;
  bit  tag_pend;
  localparam logic [127:0] OUT_PAD = 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;

  always @(negedge clk) begin
    logic [132:0] r;
    if (!clrn) begin
      nr_cnt = 0; tag_pend = 0; pend_q.delete(); exp_out_q.delete();
      dii_data_not_ready = 1'b0; Out_vld = 1'b0; Tag_vld = 1'b0;
    end else begin
      // While the core says not-ready, the sequencer must neither offer nor send.
      if (dii_data_not_ready) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_vld", dii_data_vld, 0);
      end
      Out_vld = 1'b0; Tag_vld = 1'b0;
      if (cii_ctl_vld) nr_cnt = iv_stall;
      if (dii_data_vld) begin
        nr_cnt = blk_stall;
        if (!dii_data_type) pend_q.push_back({dii_last_word, dii_data_size, dii_data ^ OUT_PAD});
        if (dii_last_word) tag_pend = 1;
      end
      dii_data_not_ready = (nr_cnt != 0);
      if (nr_cnt != 0) nr_cnt--;
      if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        r = pend_q.pop_front();
        exp_out_q.push_back(r);
        Out_vld = 1'b1;
        {Out_last_word, Out_data_size, Out_data} = r;
      end else if (tag_pend && pend_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        Out_vld = 1'b1; Tag_vld = 1'b1; Out_data = exp_tag; Out_data_size = 4'hf;
        tag_pend = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  bit prev_vld, prev_last;

  always @(negedge clk) begin
    logic [133:0] e;
    logic [132:0] o;
    if (!clrn) begin
      prev_vld = 0; prev_last = 0;
    end else begin
      if (cii_ctl_vld) begin
        check("key_expected", key_exp, 1);
        check("cii_K", cii_K, exp_key);
        key_exp = 0;
      end
      if (cii_IV_vld && !iv_seen) begin
        check("iv", dii_data, exp_iv);
        iv_seen = 1;
      end
      if (dii_data_vld) begin
        vld_cnt++;
        check("vld_pulse", prev_vld, 0);
        check("dii_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("dii_blk", {dii_data_type, dii_last_word, dii_data_size, dii_data}, e);
        end
      end
      if (prev_last && job_busy) check("last_hold", dii_last_word, 1);
      if (out_valid) begin
        n_out++;
        check("out_expected", exp_out_q.size() > 0, 1);
        if (exp_out_q.size() > 0) begin
          o = exp_out_q.pop_front();
          check("out_blk", {out_last, out_size, out_data}, o);
        end
      end
      if (tag_valid) begin
        done_cnt++;
        check("tag", tag, exp_tag);
        check("job_done", job_done, 1);
        check("out_cnt", n_out, exp_nout);
        check("dii_left", exp_q.size(), 0);
      end else begin
        check("done_alone", job_done, 0);
      end
      prev_vld  = dii_data_vld;
      prev_last = dii_last_word;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Split one length into 16-byte chunks and queue the expected core blocks.
  task automatic plan(input bit is_aad, input int len, input bit no_pld);
    int r, n;
    logic [127:0] d, m;
    r = len;
    while (r > 0) begin
      n = (r > 16) ? 16 : r;
      d = rnd128();
      m = '0;
      for (int b = 0; b < 16; b++) if (b < n) m[b*8 +: 8] = d[b*8 +: 8];
      blk_data_q.push_back(d);
      exp_q.push_back({is_aad, (r <= 16) && (!is_aad || no_pld), 4'(n - 1), m});
      r -= n;
    end
  endtask

  task automatic start_job(input logic [127:0] k, input logic [127:0] iv,
                           input int aad, input int pld, input logic [127:0] t);
    exp_key = k; exp_iv = iv; exp_tag = t;
    key_exp = 1; iv_seen = 0; n_out = 0; exp_nout = (pld + 15) / 16;
    plan(1, aad, pld == 0);
    plan(0, pld, 0);
    job_key = k; job_iv = iv;
    job_aad_len = LEN_W'(aad); job_pld_len = LEN_W'(pld);
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    check("busy_after_start", job_busy, 1);
  endtask

  task automatic send_block(input logic [127:0] d);
    int t;
    in_data = d; in_valid = 1'b1; t = 0;
    while (!in_ready && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) check("in_ready_timeout", t, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = rnd128();
  endtask

  task automatic feed_n(input int nmax, input bit spurious);
    int k;
    k = 0;
    while (blk_data_q.size() > 0 && k < nmax) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_block(blk_data_q.pop_front());
      if (spurious && k == 0) begin
        // Busy job: this descriptor must be ignored entirely.
        job_key = ~exp_key; job_iv = ~exp_iv;
        job_aad_len = LEN_W'(7); job_pld_len = LEN_W'(9);
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
      end
      k++;
    end
  endtask

  task automatic wait_done();
    int t, d0;
    d0 = done_cnt; t = 0;
    while (done_cnt == d0 && t < 3000) begin @(negedge clk); t++; end
    check("tag_arrived", done_cnt - d0, 1);
    @(negedge clk);
    check("idle_after_tag", job_busy, 0);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_ctl"}, {job_busy, job_done, job_err, in_ready, out_size, out_valid,
                          out_last, tag_valid, cii_ctl_vld, cii_IV_vld, dii_data_size,
                          dii_data_vld, dii_data_type, dii_last_word}, 0);
    check({pfx, "_out"}, out_data, 0);
    check({pfx, "_tag"}, tag, 0);
    check({pfx, "_key"}, cii_K, 0);
    check({pfx, "_dii"}, dii_data, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t, v0, d0, a, p;
    clrn = 1'b0; job_start = 1'b0; job_key = '0; job_iv = '0;
    job_aad_len = '0; job_pld_len = '0; in_data = '0; in_valid = 1'b0;
    iv_stall = 0; blk_stall = 0; done_cnt = 0; vld_cnt = 0;
    key_exp = 0; iv_seen = 1; n_out = 0; exp_nout = 0; exp_tag = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    clrn = 1'b1;
    @(negedge clk);

    // NIST GCM test case 4 geometry
    iv_stall = 2; blk_stall = 1;
    start_job(128'hfeffe9928665731c6d6a8f9467308308,
              128'hcafebabefacedbaddecaf888, 20, 60,
              128'h5bc94fbc3221a5db94fae95ae7121a47);
    feed_n(100, 0);
    wait_done();

    // Payload only, exactly one full block
    start_job(rnd128(), rnd128(), 0, 16, rnd128());
    feed_n(100, 0);
    wait_done();

    // AAD only, short block: tag with no out_valid
    start_job(rnd128(), rnd128(), 5, 0, rnd128());
    feed_n(100, 0);
    wait_done();

    // Empty descriptor
    job_aad_len = '0; job_pld_len = '0; job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    check("err_pulse", job_err, 1);
    check("err_not_busy", job_busy, 0);
    @(negedge clk);
    check("err_one_cycle", job_err, 0);
    check("err_still_idle", job_busy, 0);

    // job_start while busy is ignored
    start_job(rnd128(), rnd128(), 20, 40, rnd128());
    feed_n(100, 1);
    wait_done();

    // Long core stall after each block, then a host gap of 10 cycles
    blk_stall = 20;
    start_job(rnd128(), rnd128(), 0, 48, rnd128());
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    check("fetch_reached", in_ready, 1);
    v0 = vld_cnt;
    repeat (10) @(negedge clk);
    check("gap_no_vld", vld_cnt - v0, 0);
    feed_n(100, 0);
    wait_done();
    blk_stall = 1;

    // Reset in the middle of the payload
    start_job(rnd128(), rnd128(), 0, 64, rnd128());
    feed_n(2, 0);
    d0 = done_cnt;
    #2 clrn = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    check("midrst_busy", job_busy, 0);
    #2 clrn = 1'b1;
    exp_q.delete(); blk_data_q.delete();
    repeat (5) @(negedge clk);
    check("midrst_no_tag", done_cnt - d0, 0);
    start_job(rnd128(), rnd128(), 3, 33, rnd128());
    feed_n(100, 0);
    wait_done();

    // Random jobs
    for (int j = 0; j < 8; j++) begin
      a = $urandom_range(0, 40);
      p = $urandom_range(0, 70);
      if (a == 0 && p == 0) p = 1;
      iv_stall = $urandom_range(0, 3);
      blk_stall = $urandom_range(0, 4);
      start_job(rnd128(), rnd128(), a, p, rnd128());
      feed_n(100, 0);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
